// File: rtl/osd_spi_pkg.sv
// Shared definitions for the OSD SPI initiator: op codes, command bytes and FSM states.
package osd_spi_pkg;

  localparam logic [1:0] OP_DISABLE  = 2'd0;
  localparam logic [1:0] OP_ENABLE   = 2'd1;
  localparam logic [1:0] OP_WRITE    = 2'd2;
  localparam logic [1:0] OP_RESERVED = 2'd3;

  localparam logic [7:0] CMD_DISABLE    = 8'h40;
  localparam logic [7:0] CMD_ENABLE     = 8'h41;
  localparam logic [7:0] CMD_WRITE_BASE = 8'h20;

  localparam int OSD_LINE_BYTES = 256;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_LOAD,
    ST_HOLD,
    ST_GAP
  } osd_state_e;

  // Command byte sent first in every frame; the write line sits in the low three bits.
  function automatic logic [7:0] cmd_byte(input logic [1:0] op, input logic [2:0] line);
    case (op)
      OP_DISABLE: return CMD_DISABLE;
      OP_ENABLE:  return CMD_ENABLE;
      default:    return CMD_WRITE_BASE | {5'd0, line};
    endcase
  endfunction

endpackage

// File: rtl/osd_spi_if.sv
// Core-side command/payload bus of the OSD SPI initiator.
// Handshake: a command transfers on a clock edge where cmd_valid && cmd_ready; a payload
// byte transfers on an edge where data_valid && data_ready. data_ready is only ever high in
// the cycle the byte is taken, so the source may hold data_valid high at any time.
interface osd_spi_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [2:0] cmd_line;
  logic       data_valid;
  logic       data_ready;
  logic [7:0] data_byte;
  logic       busy;
  logic       done;

  modport master (
    output cmd_valid, cmd_op, cmd_line, data_valid, data_byte,
    input  cmd_ready, data_ready, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_line, data_valid, data_byte,
    output cmd_ready, data_ready, busy, done
  );
endinterface

// File: rtl/osd_spi_shifter.sv
// 8-bit MSB-first serialiser: each bit is CLK_DIV clocks with sck low, then CLK_DIV with sck high.
// sdi only moves on the falling edge of sck (or on start, while sck is low).
module osd_spi_shifter #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       nRESET,
  input  logic       start,
  input  logic [7:0] din,
  output logic       sck,
  output logic       sdi,
  output logic       last
);

  logic [7:0] shreg;
  logic [2:0] bit_cnt;
  logic [7:0] div_cnt;
  logic       active;
  logic       phase_end;

  assign phase_end = (div_cnt == 8'(CLK_DIV - 1));
  assign sdi       = shreg[7];
  // High in the final clock of the 8th bit's high phase.
  assign last      = active && sck && phase_end && (bit_cnt == 3'd7);

  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      active  <= 1'b0;
      shreg   <= '0;
      bit_cnt <= '0;
      div_cnt <= '0;
      sck     <= 1'b0;
    end else if (start) begin
      active  <= 1'b1;
      shreg   <= din;
      bit_cnt <= '0;
      div_cnt <= '0;
      sck     <= 1'b0;
    end else if (active) begin
      if (phase_end) begin
        div_cnt <= '0;
        sck     <= ~sck;
        if (sck) begin
          // Shifting in zeros leaves sdi low once the byte is out.
          shreg   <= {shreg[6:0], 1'b0};
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) active <= 1'b0;
        end
      end else begin
        div_cnt <= div_cnt + 8'd1;
      end
    end
  end

endmodule

// File: rtl/osd_spi_master.sv
// SPI initiator for the OSD link: frames enable/disable/write-line commands and the
// 256-byte line payload onto ss/sck/sdi.
module osd_spi_master
  import osd_spi_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int SS_SETUP = 2,
  parameter int SS_GAP   = 4
) (
  input  logic        clk,
  input  logic        nRESET,
  osd_spi_if.slave    bus,
  output logic        sck,
  output logic        ss,
  output logic        sdi,
  output osd_state_e  state_dbg
);

  osd_state_e state, state_nx;
  logic [7:0] wcnt;
  logic [1:0] op_q;
  logic [2:0] line_q;
  logic [8:0] pay_cnt;

  logic       accept;
  logic       load_byte;
  logic       sh_start;
  logic [7:0] sh_din;
  logic       sh_last;
  logic       done_c;
  logic       data_ready_c;

  osd_spi_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
    .clk    (clk),
    .nRESET (nRESET),
    .start  (sh_start),
    .din    (sh_din),
    .sck    (sck),
    .sdi    (sdi),
    .last   (sh_last)
  );

  always_comb begin
    state_nx     = state;
    accept       = 1'b0;
    load_byte    = 1'b0;
    sh_start     = 1'b0;
    sh_din       = cmd_byte(op_q, line_q);
    done_c       = 1'b0;
    data_ready_c = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          accept   = 1'b1;
          // The reserved op produces no traffic but still completes through GAP.
          state_nx = (bus.cmd_op == OP_RESERVED) ? ST_GAP : ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (wcnt == 8'(SS_SETUP - 1)) begin
          sh_start = 1'b1;
          state_nx = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (sh_last) begin
          state_nx = (op_q == OP_WRITE && pay_cnt != 9'(OSD_LINE_BYTES)) ? ST_LOAD : ST_HOLD;
        end
      end
      ST_LOAD: begin
        // sck stays low here for as long as the source stalls.
        if (bus.data_valid) begin
          data_ready_c = 1'b1;
          load_byte    = 1'b1;
          sh_start     = 1'b1;
          sh_din       = bus.data_byte;
          state_nx     = ST_SHIFT;
        end
      end
      ST_HOLD: begin
        if (wcnt == 8'(CLK_DIV - 1)) state_nx = ST_GAP;
      end
      ST_GAP: begin
        if (wcnt == 8'(SS_GAP - 1)) begin
          done_c   = 1'b1;
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      state   <= ST_IDLE;
      wcnt    <= '0;
      op_q    <= OP_DISABLE;
      line_q  <= '0;
      pay_cnt <= '0;
    end else begin
      state <= state_nx;
      wcnt  <= (state_nx != state) ? 8'd0 : wcnt + 8'd1;
      if (accept) begin
        op_q    <= bus.cmd_op;
        line_q  <= bus.cmd_line;
        pay_cnt <= '0;
      end else if (load_byte) begin
        pay_cnt <= pay_cnt + 9'd1;
      end
    end
  end

  // cmd_ready is gated by reset so it reads low while nRESET is asserted.
  assign bus.cmd_ready  = (state == ST_IDLE) && nRESET;
  assign bus.data_ready = data_ready_c;
  assign bus.busy       = (state != ST_IDLE);
  assign bus.done       = done_c;
  assign ss             = !(state inside {ST_SETUP, ST_SHIFT, ST_LOAD, ST_HOLD});
  assign state_dbg      = state;

endmodule

// File: doc/osd_spi_master.md
Name: osd_spi_master

Overview:
- SPI initiator that drives the OSD's sck/ss/sdi link from the core side, replacing the external IO controller for on-FPGA OSD control.
- Accepts enable, disable and write-line commands plus a byte stream, and serialises them MSB first in the framing the OSD receiver decodes.
- Sits in the menu/debug controller, clocked from the system clock; its outputs connect directly to the OSD SPI inputs.

Parameters:
- CLK_DIV, 4, clk cycles per sck half-period; legal range 1..255.
- SS_SETUP, 2, clk cycles from ss falling to the first sdi/sck activity.
- SS_GAP, 4, clk cycles ss is held high between transactions.

Ports:
- clk  in  1  system clock
- nRESET  in  1  asynchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high in IDLE only; command accepted when cmd_valid && cmd_ready
- cmd_op  in  2  0=disable, 1=enable, 2=write line, 3=reserved (accepted, no SPI traffic, done pulses)
- cmd_line  in  3  OSD line for write (0..7)
- data_valid  in  1  payload byte available
- data_ready  out  1  one-cycle pulse when data_byte is consumed
- data_byte  in  8  payload byte
- busy  out  1  high from acceptance until GAP ends
- done  out  1  one-cycle pulse on GAP exit
- sck  out  1  SPI clock, idle low
- ss  out  1  slave select, active low, idle high
- sdi  out  1  serial data to OSD

Behaviour:
- Reset (asynchronous, nRESET=0): ss=1, sck=0, sdi=0, busy=0, done=0, cmd_ready=0, data_ready=0, FSM=IDLE, counters=0. Reset asserted mid-transaction aborts immediately with the same values. The OSD sees ss rise and discards the partial frame.
- The SPI mode matches the OSD receiver: sdi changes while sck is low and is sampled on the sck rising edge, MSB first. Each bit is CLK_DIV cycles low followed by CLK_DIV cycles high. sck returns low after the last bit.
- Command byte encoding:
  - disable = 0x40
  - enable = 0x41
  - write = 0x20 | cmd_line
- Write command: the command byte is followed by exactly 256 payload bytes. The OSD buffer address is cmd_line*256 + index, so index wraps at 255→end. The payload counter is 9 bits; the frame ends when the count reaches 256.
- FSM states:
  - IDLE: cmd_ready=1. On accept, latch op and line, set busy=1, go to SETUP. For op 3, go directly to GAP with ss kept high.
  - SETUP: ss=0, wait SS_SETUP cycles, load the command byte into the shift register, go to SHIFT.
  - SHIFT: 8 bits at CLK_DIV timing. After the 8th bit's high phase ends, go to LOAD for a write with bytes remaining, otherwise go to HOLD.
  - LOAD: wait for data_valid with sck held low; the stall length is unbounded and legal. When data_valid=1, pulse data_ready, load data_byte, increment the payload count, go to SHIFT.
  - HOLD: sck low for CLK_DIV cycles, then ss=1, go to GAP.
  - GAP: ss=1 for SS_GAP cycles. On exit, pulse done, clear busy, go to IDLE.
- Timing and guard rules:
  - SPI latency for enable/disable: acceptance → ss falling takes 1 cycle. ss low lasts SS_SETUP + 16*CLK_DIV + CLK_DIV cycles.
  - cmd_valid is ignored while busy. data_valid is ignored outside LOAD; no byte is ever consumed outside LOAD.
  - cmd_valid and the done pulse in the same cycle: done is observed and cmd_ready is low. The command is accepted on the next cycle.
  - sck never exceeds clk/2. CLK_DIV=1 gives clk/2.

Decomposition:
- Package osd_spi_pkg holds:
  - op codes OP_DISABLE/OP_ENABLE/OP_WRITE
  - command bytes CMD_DISABLE=8'h40, CMD_ENABLE=8'h41, CMD_WRITE_BASE=8'h20
  - OSD_LINE_BYTES=256
  - FSM state enum
- Sub-module osd_spi_shifter: 8-bit MSB-first shifter with CLK_DIV divider, start/last-bit handshake, and sck/sdi generation. The top level keeps the FSM, payload counter and ss.

Test Plan:
- Enable, CLK_DIV=2: op=1 → ss low once; an SPI monitor captures exactly 0x41 and 8 sck rising edges; done pulses once; busy then clears.
- Disable then enable back-to-back, cmd_valid held high: bytes 0x40 then 0x41 appear in two separate ss frames; ss is high for ≥SS_GAP cycles between them.
- Write line 5, payload 0x00..0xFF, data_valid always high: the frame contains 0x25 followed by 256 bytes in order; data_ready pulses exactly 256 times. A connected osd instance shows osd_buffer[0x500+i]==i.
- Write with data_valid dropped for 50 cycles at byte 100: sck stays low and ss stays low during the stall. No byte is duplicated or skipped, and the received stream is identical to the no-stall case.
- nRESET asserted at byte 30 of a write: ss=1, sck=0, sdi=0 and busy=0 without waiting for a clock. A following enable produces a clean frame of 0x41.
- op=3: no ss activity; done pulses after SS_GAP+1 cycles; data_ready never pulses.
